// File: rtl/rr_arbiter_if.sv
// Requester-side bundle of the round-robin arbiter: request/done in, registered grant out.
// The arbiter takes the slave view; the requester bank takes the master view.
interface rr_arbiter_if #(
    parameter int N     = 4,
    parameter int LOG2N = 2
);
    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     gnt;
    logic [LOG2N-1:0] gnt_idx;
    logic             gnt_valid;
    logic             timeout;

    modport master (
        output req, done,
        input  gnt, gnt_idx, gnt_valid, timeout
    );

    modport slave (
        input  req, done,
        output gnt, gnt_idx, gnt_valid, timeout
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants one requester at a time, holds the grant until done,
// withdrawal or hold timeout, then makes the served requester lowest priority.
module rr_arbiter #(
    parameter int N       = 4,
    parameter int LOG2N   = 2,
    parameter int TO_W    = 8,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    rr_arbiter_if.slave     bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_next;
    logic [N-1:0]     gnt_q, gnt_next;
    logic [LOG2N-1:0] idx_q, idx_next;
    logic             valid_q, valid_next;
    logic             to_q, to_next;
    logic [LOG2N-1:0] last_q, last_next;
    logic [TO_W-1:0]  cnt_q, cnt_next;

    logic [N-1:0]     below_last;
    logic [N-1:0]     req_below;
    logic [LOG2N-1:0] win;

    // Requesters below `last` are searched first (highest of them wins); if none,
    // the highest pending overall wins, which leaves `last` itself for the very end.
    always_comb begin
        below_last = '0;
        for (int i = 0; i < N; i++) begin
            below_last[i] = (i < int'(last_q));
        end
        req_below = bus.req & below_last;
        win = '0;
        for (int i = 0; i < N; i++) begin
            if ((req_below != '0) ? req_below[i] : bus.req[i]) begin
                win = LOG2N'(i);
            end
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_next = state;
        gnt_next   = gnt_q;
        idx_next   = idx_q;
        valid_next = valid_q;
        to_next    = 1'b0;
        last_next  = last_q;
        cnt_next   = cnt_q;

        case (state)
            IDLE: begin
                gnt_next   = '0;
                valid_next = 1'b0;
                if (bus.req != '0) begin
                    state_next = BUSY;
                    gnt_next   = N'(1) << win;
                    idx_next   = win;
                    valid_next = 1'b1;
                    cnt_next   = '0;
                end
            end
            BUSY: begin
                if (bus.done || !bus.req[idx_q] ||
                    (TIMEOUT != 0 && cnt_q == TO_W'(TIMEOUT - 1))) begin
                    // done and withdrawal take precedence over the timeout pulse
                    to_next    = !bus.done && bus.req[idx_q];
                    state_next = IDLE;
                    gnt_next   = '0;
                    valid_next = 1'b0;
                    last_next  = idx_q;
                end else if (cnt_q != '1) begin
                    cnt_next = cnt_q + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state   <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            to_q    <= 1'b0;
            last_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_next;
            gnt_q   <= gnt_next;
            idx_q   <= idx_next;
            valid_q <= valid_next;
            to_q    <= to_next;
            last_q  <= last_next;
            cnt_q   <= cnt_next;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = idx_q;
    assign bus.gnt_valid = valid_q;
    assign bus.timeout   = to_q;
endmodule
